// File: rtl/pwm_capture_2ch_pkg.sv
// Shared definitions for the two-channel PWM capture block:
// default counter width, default glitch-filter length and the per-channel FSM states.
package pwm_capture_2ch_pkg;

    localparam int PWMWIDTH_DEF = 16;
    localparam int FILT_LEN_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_2ch_ch.sv
// One capture channel: synchronizer, optional glitch filter, edge detect,
// saturating tick counter, measurement FSM and valid/ack result handshake.
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN (level change needs FILT_LEN stable ce samples).
// Handshake: valid stays high from a publish until ack is seen on a clk edge; a publish while
// valid is high overwrites the data and sets ovr, unless ack arrives on that same edge.
module pwm_capture_2ch_ch
    import pwm_capture_2ch_pkg::*;
#(
    parameter int PWMWIDTH = PWMWIDTH_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                en_cap,
    input  logic                sig_pwm,
    input  logic                ack,
    output logic [PWMWIDTH-1:0] period,
    output logic [PWMWIDTH-1:0] high,
    output logic                valid,
    output logic                ovr,
    output logic                stuck,
    output logic                level,
    output cap_state_t          state
);

    localparam logic [PWMWIDTH-1:0] CNT_MAX = '1;

    logic                sync_1, sync_2;
    logic                lvl;
    logic                lvl_p1, lvl_p2;
    logic                rise, fall;
    logic [PWMWIDTH-1:0] cnt_q, cnt_inc, high_lat;
    cap_state_t          state_q, state_next;
    logic                publish, latch_high;

    // Two-flop synchronizer for the asynchronous PWM input, runs every clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= sig_pwm;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    logic           filt_q;
    logic [FCW-1:0] fcnt;

    // Accept a new level only after FILT_LEN consecutive ce samples of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
            fcnt   <= '0;
        end else if (ce) begin
            if (sync_2 == filt_q) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILT_LEN - 1)) begin
                filt_q <= sync_2;
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + FCW'(1);
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_2;
`endif

    // Two-deep history of the filtered level; edges are seen one ce tick after the level lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_p1 <= 1'b0;
            lvl_p2 <= 1'b0;
        end else if (ce) begin
            lvl_p1 <= lvl;
            lvl_p2 <= lvl_p1;
        end
    end

    assign rise    = lvl_p1 & ~lvl_p2;
    assign fall    = ~lvl_p1 & lvl_p2;
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PWMWIDTH'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_next;
    end

    // Next state and the publish / high-latch strobes.
    always_comb begin
        state_next = state_q;
        publish    = 1'b0;
        latch_high = 1'b0;
        if (!en_cap) begin
            state_next = ST_IDLE;
        end else if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) state_next = ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        latch_high = 1'b1;
                        state_next = ST_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        state_next = ST_STUCK;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        publish    = 1'b1;
                        state_next = ST_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_next = ST_STUCK;
                    end
                end
                ST_STUCK: begin
                    if (rise) state_next = ST_HIGH;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Tick counter: restarts on each rise, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!en_cap) begin
            cnt_q <= '0;
        end else if (ce) begin
            if (rise) cnt_q <= '0;
            else      cnt_q <= cnt_inc;
        end
    end

    // High time is held here until the closing rise publishes it with the period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            high_lat <= '0;
        else if (latch_high) high_lat <= cnt_inc;
    end

    // Result registers and valid/ovr handshake; ack is honoured on every clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= '0;
            high   <= '0;
            valid  <= 1'b0;
            ovr    <= 1'b0;
        end else if (publish) begin
            period <= cnt_inc;
            high   <= high_lat;
            valid  <= 1'b1;
            if (ack)        ovr <= 1'b0;
            else if (valid) ovr <= 1'b1;
        end else if (ack && valid) begin
            valid <= 1'b0;
            ovr   <= 1'b0;
        end
    end

    assign stuck = (state_q == ST_STUCK);
    assign level = lvl;
    assign state = state_q;

endmodule

// File: rtl/pwm_capture_2ch.sv
// Two-channel PWM capture top: two independent capture channels sharing ce and en_cap.
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN (applied inside each channel).
module pwm_capture_2ch
    import pwm_capture_2ch_pkg::*;
#(
    parameter int PWMWIDTH = PWMWIDTH_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                en_cap,
    input  logic                sig_pwm_1,
    input  logic                sig_pwm_2,
    input  logic                ack_1,
    input  logic                ack_2,
    output logic [PWMWIDTH-1:0] period_1,
    output logic [PWMWIDTH-1:0] high_1,
    output logic                valid_1,
    output logic                ovr_1,
    output logic                stuck_1,
    output logic                level_1,
    output logic [PWMWIDTH-1:0] period_2,
    output logic [PWMWIDTH-1:0] high_2,
    output logic                valid_2,
    output logic                ovr_2,
    output logic                stuck_2,
    output logic                level_2,
    output cap_state_t          dbg_state_1,
    output cap_state_t          dbg_state_2
);

    pwm_capture_2ch_ch #(.PWMWIDTH(PWMWIDTH), .FILT_LEN(FILT_LEN)) u_ch_1 (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .en_cap  (en_cap),
        .sig_pwm (sig_pwm_1),
        .ack     (ack_1),
        .period  (period_1),
        .high    (high_1),
        .valid   (valid_1),
        .ovr     (ovr_1),
        .stuck   (stuck_1),
        .level   (level_1),
        .state   (dbg_state_1)
    );

    pwm_capture_2ch_ch #(.PWMWIDTH(PWMWIDTH), .FILT_LEN(FILT_LEN)) u_ch_2 (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .en_cap  (en_cap),
        .sig_pwm (sig_pwm_2),
        .ack     (ack_2),
        .period  (period_2),
        .high    (high_2),
        .valid   (valid_2),
        .ovr     (ovr_2),
        .stuck   (stuck_2),
        .level   (level_2),
        .state   (dbg_state_2)
    );

endmodule

// File: tb/tb_pwm_capture_2ch.sv
// Directed testbench for pwm_capture_2ch with hand-computed expected values.
module tb_pwm_capture_2ch;
    import pwm_capture_2ch_pkg::*;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 4 + FILT_LEN_DEF;
`else
    localparam int LAT = 4;
`endif

    logic        clk, rst, ce, en_cap;
    logic        sig_pwm_1, sig_pwm_2, ack_1, ack_2;
    logic [15:0] period_1, high_1, period_2, high_2;
    logic        valid_1, ovr_1, stuck_1, level_1;
    logic        valid_2, ovr_2, stuck_2, level_2;
    cap_state_t  dbg_state_1, dbg_state_2;

    int n_cmp  = 0;
    int n_fail = 0;
    int ce_div = 1;
    int cyc    = 0;

    pwm_capture_2ch dut (
        .clk(clk), .rst(rst), .ce(ce), .en_cap(en_cap),
        .sig_pwm_1(sig_pwm_1), .sig_pwm_2(sig_pwm_2), .ack_1(ack_1), .ack_2(ack_2),
        .period_1(period_1), .high_1(high_1), .valid_1(valid_1), .ovr_1(ovr_1),
        .stuck_1(stuck_1), .level_1(level_1),
        .period_2(period_2), .high_2(high_2), .valid_2(valid_2), .ovr_2(ovr_2),
        .stuck_2(stuck_2), .level_2(level_2),
        .dbg_state_1(dbg_state_1), .dbg_state_2(dbg_state_2)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            ce = (ce_div == 1) ? 1'b1 : ((cyc % ce_div) == 0);
        end
    endtask

    task automatic pwm1(input int per, input int hi);
        sig_pwm_1 = 1'b1;
        tick(hi);
        sig_pwm_1 = 1'b0;
        tick(per - hi);
    endtask

    task automatic pwm2(input int per, input int hi);
        sig_pwm_2 = 1'b1;
        tick(hi);
        sig_pwm_2 = 1'b0;
        tick(per - hi);
    endtask

    task automatic pulse_ack(input int ch);
        if (ch == 1) ack_1 = 1'b1;
        else         ack_2 = 1'b1;
        tick(1);
        ack_1 = 1'b0;
        ack_2 = 1'b0;
    endtask

    task automatic restart();
        sig_pwm_1 = 1'b0;
        sig_pwm_2 = 1'b0;
        tick(10 * ce_div);
        en_cap = 1'b0;
        tick(2);
        en_cap = 1'b1;
        tick(1);
    endtask

    // Scenario tasks
    task automatic test_reset();
        #3;
        n_cmp++;
        if ({period_1, high_1, valid_1, ovr_1, stuck_1, level_1} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_ch1: got %h expected 0", {period_1, high_1, valid_1, ovr_1, stuck_1, level_1});
        end
        n_cmp++;
        if ({period_2, high_2, valid_2, ovr_2, stuck_2, level_2} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_ch2: got %h expected 0", {period_2, high_2, valid_2, ovr_2, stuck_2, level_2});
        end
        tick(3);
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if (dbg_state_1 !== ST_IDLE || dbg_state_2 !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d/%0d expected 0/0", dbg_state_1, dbg_state_2);
        end
    endtask

    task automatic test_basic();
        restart();
        pwm1(100, 30);
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first_rise: got valid_1=%0b expected 0", valid_1);
        end
        sig_pwm_1 = 1'b1;
        tick(LAT - 1);
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got valid_1=%0b expected 0", valid_1);
        end
        tick(1);
        n_cmp++;
        if (valid_1 !== 1'b1 || period_1 !== 16'd100 || high_1 !== 16'd30) begin
            n_fail++;
            $display("FAIL basic_result: got v=%0b p=%0d h=%0d expected v=1 p=100 h=30", valid_1, period_1, high_1);
        end
        n_cmp++;
        if (ovr_1 !== 1'b0 || level_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ovr_level: got ovr=%0b lvl=%0b expected 0/1", ovr_1, level_1);
        end
        pulse_ack(1);
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack: got valid_1=%0b expected 0", valid_1);
        end
    endtask

    task automatic test_ce_div();
        ce_div = 4;
        restart();
        pwm2(400, 100);
        sig_pwm_2 = 1'b1;
        tick(4 * LAT + 8);
        n_cmp++;
        if (valid_2 !== 1'b1 || period_2 !== 16'd100 || high_2 !== 16'd25) begin
            n_fail++;
            $display("FAIL cediv_result: got v=%0b p=%0d h=%0d expected v=1 p=100 h=25", valid_2, period_2, high_2);
        end
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL cediv_ch1_quiet: got valid_1=%0b expected 0", valid_1);
        end
        if (ce) tick(1);
        pulse_ack(2);
        n_cmp++;
        if (valid_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL cediv_ack_no_ce: got valid_2=%0b expected 0", valid_2);
        end
        ce_div = 1;
    endtask

    task automatic test_overwrite();
        restart();
        pwm1(100, 30);
        pwm1(120, 40);
        n_cmp++;
        if (valid_1 !== 1'b1 || period_1 !== 16'd100 || high_1 !== 16'd30) begin
            n_fail++;
            $display("FAIL ovr_first_pub: got v=%0b p=%0d h=%0d expected v=1 p=100 h=30", valid_1, period_1, high_1);
        end
        sig_pwm_1 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (period_1 !== 16'd120 || high_1 !== 16'd40 || valid_1 !== 1'b1 || ovr_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_overwrite: got p=%0d h=%0d v=%0b o=%0b expected p=120 h=40 v=1 o=1", period_1, high_1, valid_1, ovr_1);
        end
        pulse_ack(1);
        n_cmp++;
        if (valid_1 !== 1'b0 || ovr_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_ack_clear: got v=%0b o=%0b expected 0/0", valid_1, ovr_1);
        end
        pulse_ack(1);
        n_cmp++;
        if (valid_1 !== 1'b0 || ovr_1 !== 1'b0 || period_1 !== 16'd120) begin
            n_fail++;
            $display("FAIL ovr_idle_ack: got v=%0b o=%0b p=%0d expected 0/0/120", valid_1, ovr_1, period_1);
        end
        tick(30 - (LAT + 2));
        sig_pwm_1 = 1'b0;
        tick(70);
        sig_pwm_1 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (valid_1 !== 1'b1 || ovr_1 !== 1'b0 || period_1 !== 16'd100 || high_1 !== 16'd30) begin
            n_fail++;
            $display("FAIL ovr_repub: got v=%0b o=%0b p=%0d h=%0d expected 1/0/100/30", valid_1, ovr_1, period_1, high_1);
        end
        tick(50 - LAT);
        sig_pwm_1 = 1'b0;
        tick(50);
        sig_pwm_1 = 1'b1;
        tick(LAT - 1);
        ack_1 = 1'b1;
        tick(1);
        ack_1 = 1'b0;
        n_cmp++;
        if (valid_1 !== 1'b1 || ovr_1 !== 1'b0 || period_1 !== 16'd100 || high_1 !== 16'd50) begin
            n_fail++;
            $display("FAIL ovr_pub_and_ack: got v=%0b o=%0b p=%0d h=%0d expected 1/0/100/50", valid_1, ovr_1, period_1, high_1);
        end
        pulse_ack(1);
    endtask

    task automatic test_stuck();
        restart();
        sig_pwm_1 = 1'b1;
        tick(LAT + 65535);
        n_cmp++;
        if (stuck_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_early: got stuck_1=%0b expected 0", stuck_1);
        end
        tick(1);
        n_cmp++;
        if (stuck_1 !== 1'b1 || dbg_state_1 !== ST_STUCK || level_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_enter: got s=%0b st=%0d l=%0b expected 1/3/1", stuck_1, dbg_state_1, level_1);
        end
        n_cmp++;
        if (valid_1 !== 1'b0 || high_1 !== 16'd50 || period_1 !== 16'd100) begin
            n_fail++;
            $display("FAIL stuck_hold: got v=%0b h=%0d p=%0d expected 0/50/100", valid_1, high_1, period_1);
        end
        tick(70000 - (LAT + 65536));
        sig_pwm_1 = 1'b0;
        tick(50);
        n_cmp++;
        if (stuck_1 !== 1'b1 || level_1 !== 1'b0 || valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_fall_ignored: got s=%0b l=%0b v=%0b expected 1/0/0", stuck_1, level_1, valid_1);
        end
        sig_pwm_1 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (stuck_1 !== 1'b0 || valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_exit: got s=%0b v=%0b expected 0/0", stuck_1, valid_1);
        end
        tick(30 - LAT);
        sig_pwm_1 = 1'b0;
        tick(70);
        sig_pwm_1 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (valid_1 !== 1'b1 || period_1 !== 16'd100 || high_1 !== 16'd30) begin
            n_fail++;
            $display("FAIL stuck_recover: got v=%0b p=%0d h=%0d expected 1/100/30", valid_1, period_1, high_1);
        end
    endtask

    task automatic test_async_reset();
        tick(30 - LAT);
        sig_pwm_1 = 1'b0;
        tick(70);
        sig_pwm_1 = 1'b1;
        sig_pwm_2 = 1'b1;
        tick(40);
        sig_pwm_1 = 1'b0;
        sig_pwm_2 = 1'b0;
        tick(60);
        sig_pwm_1 = 1'b1;
        sig_pwm_2 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (period_1 !== 16'd100 || high_1 !== 16'd40 || ovr_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL par_ch1: got p=%0d h=%0d o=%0b expected 100/40/1", period_1, high_1, ovr_1);
        end
        n_cmp++;
        if (valid_2 !== 1'b1 || period_2 !== 16'd100 || high_2 !== 16'd40 || ovr_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL par_ch2: got v=%0b p=%0d h=%0d o=%0b expected 1/100/40/0", valid_2, period_2, high_2, ovr_2);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({period_1, high_1, valid_1, ovr_1, stuck_1, level_1,
             period_2, high_2, valid_2, ovr_2, stuck_2, level_2} !== 72'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {period_1, high_1, valid_1, ovr_1, stuck_1, level_1, period_2, high_2, valid_2, ovr_2, stuck_2, level_2});
        end
        n_cmp++;
        if (dbg_state_1 !== ST_IDLE || dbg_state_2 !== ST_IDLE) begin
            n_fail++;
            $display("FAIL async_reset_state: got %0d/%0d expected 0/0", dbg_state_1, dbg_state_2);
        end
        sig_pwm_1 = 1'b0;
        sig_pwm_2 = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(10);
        pwm1(100, 30);
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_discard: got valid_1=%0b expected 0", valid_1);
        end
        sig_pwm_1 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (valid_1 !== 1'b1 || period_1 !== 16'd100 || high_1 !== 16'd30 || valid_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_result: got v1=%0b p=%0d h=%0d v2=%0b expected 1/100/30/0", valid_1, period_1, high_1, valid_2);
        end
    endtask

    task automatic test_en_cap();
        sig_pwm_2 = 1'b1;
        tick(LAT + 5);
        n_cmp++;
        if (dbg_state_2 !== ST_HIGH) begin
            n_fail++;
            $display("FAIL encap_high: got state_2=%0d expected 1", dbg_state_2);
        end
        en_cap = 1'b0;
        tick(2);
        n_cmp++;
        if (dbg_state_2 !== ST_IDLE || valid_1 !== 1'b1 || period_1 !== 16'd100) begin
            n_fail++;
            $display("FAIL encap_off: got st2=%0d v1=%0b p1=%0d expected 0/1/100", dbg_state_2, valid_1, period_1);
        end
        en_cap = 1'b1;
        tick(1);
        sig_pwm_2 = 1'b0;
        tick(50);
        sig_pwm_2 = 1'b1;
        tick(LAT);
        n_cmp++;
        if (valid_2 !== 1'b0 || dbg_state_2 !== ST_HIGH) begin
            n_fail++;
            $display("FAIL encap_first_rise: got v2=%0b st2=%0d expected 0/1", valid_2, dbg_state_2);
        end
        pulse_ack(1);
    endtask

    task automatic test_glitch();
        restart();
        sig_pwm_1 = 1'b1;
        tick(1);
        sig_pwm_1 = 1'b0;
        tick(99);
        sig_pwm_1 = 1'b1;
        tick(1);
        sig_pwm_1 = 1'b0;
        tick(LAT + 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        n_cmp++;
        if (valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_filtered: got valid_1=%0b expected 0", valid_1);
        end
`else
        n_cmp++;
        if (valid_1 !== 1'b1 || high_1 !== 16'd1 || period_1 !== 16'd100) begin
            n_fail++;
            $display("FAIL glitch_pass: got v=%0b h=%0d p=%0d expected 1/1/100", valid_1, high_1, period_1);
        end
`endif
    endtask

    // Sequence and final report
    initial begin
        rst       = 1'b0;
        ce        = 1'b1;
        en_cap    = 1'b0;
        sig_pwm_1 = 1'b0;
        sig_pwm_2 = 1'b0;
        ack_1     = 1'b0;
        ack_2     = 1'b0;
        test_reset();
        en_cap = 1'b1;
        test_basic();
        test_ce_div();
        test_overwrite();
        test_stuck();
        test_async_reset();
        test_en_cap();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
